// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, master state encoding, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_lite_pkg;

    localparam int AXI_ADDR_W_DEF = 32;
    localparam int AXI_DATA_W_DEF = 32;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } mst_state_t;

endpackage

// File: rtl/axi_lite_hs_reg.sv
// VALID-hold cell for one AXI request channel: holds VALID and payload, flags completion.
// Latency: VALID rises the cycle after i_load; drops the cycle after the VALID&&READY edge.
// Backpressure: VALID and payload stay frozen while i_ready is low; done flag clears on next load.
module axi_lite_hs_reg #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_dat,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_dat,
    output logic         o_fire,
    output logic         o_done
);

    logic         r_valid;
    logic         r_done;
    logic [W-1:0] r_dat;

    // Load payload and raise VALID; retire VALID into the done flag on handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_dat   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_done  <= 1'b0;
            r_dat   <= i_dat;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
        end
    end

    assign o_valid = r_valid;
    assign o_dat   = r_dat;
    assign o_fire  = r_valid & i_ready;
    assign o_done  = r_done;

endmodule

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: command/response port in, AW/W/B and AR/R channels out.
// Latency: request VALIDs rise the cycle after cmd accept; rsp_valid the cycle after the B/R handshake.
// Backpressure: cmd_ready only in IDLE; rsp_valid holds until rsp_ready; slave READY/VALID stalls freely.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W_DEF,
    parameter int DATA_W = AXI_DATA_W_DEF
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    // command side
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,
    // response side
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  busy,
    // write address
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [ADDR_W-1:0]     AWADDR,
    // write data
    output logic                  WVALID,
    input  logic                  WREADY,
    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    // write response
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [1:0]            BRESP,
    // read address
    output logic                  ARVALID,
    input  logic                  ARREADY,
    output logic [ADDR_W-1:0]     ARADDR,
    // read data
    input  logic                  RVALID,
    output logic                  RREADY,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [1:0]            RRESP
);

    localparam int STRB_W = DATA_W / 8;

    mst_state_t r_state;
    mst_state_t w_state_nxt;

    logic                     w_cmd_acc;
    logic                     w_ld_wr;
    logic                     w_ld_rd;
    logic                     w_aw_fire;
    logic                     w_aw_done;
    logic                     w_w_fire;
    logic                     w_w_done;
    logic                     w_ar_fire;
    logic                     w_ar_done;
    logic [DATA_W+STRB_W-1:0] w_w_dat;

    logic                     r_rsp_write;
    logic [DATA_W-1:0]        r_rsp_rdata;
    logic [1:0]               r_rsp_resp;

    // A command is taken only while idle; its direction picks which channels get loaded.
    assign w_cmd_acc = (r_state == ST_IDLE) && cmd_valid;
    assign w_ld_wr   = w_cmd_acc & cmd_write;
    assign w_ld_rd   = w_cmd_acc & ~cmd_write;

    axi_lite_hs_reg #(.W(ADDR_W)) u_aw (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_load  (w_ld_wr),
        .i_dat   (cmd_addr),
        .i_ready (AWREADY),
        .o_valid (AWVALID),
        .o_dat   (AWADDR),
        .o_fire  (w_aw_fire),
        .o_done  (w_aw_done)
    );

    axi_lite_hs_reg #(.W(DATA_W + STRB_W)) u_w (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_load  (w_ld_wr),
        .i_dat   ({cmd_wdata, cmd_wstrb}),
        .i_ready (WREADY),
        .o_valid (WVALID),
        .o_dat   (w_w_dat),
        .o_fire  (w_w_fire),
        .o_done  (w_w_done)
    );

    assign {WDATA, WSTRB} = w_w_dat;

    axi_lite_hs_reg #(.W(ADDR_W)) u_ar (
        .i_clk   (ACLK),
        .i_rst   (ARESET),
        .i_load  (w_ld_rd),
        .i_dat   (cmd_addr),
        .i_ready (ARREADY),
        .o_valid (ARVALID),
        .o_dat   (ARADDR),
        .o_fire  (w_ar_fire),
        .o_done  (w_ar_done)
    );

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded handshake outputs; B/R are only accepted in their response states.
    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        BREADY      = 1'b0;
        RREADY      = 1'b0;
        rsp_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_state_nxt = cmd_write ? ST_WR_REQ : ST_RD_REQ;
                end
            end
            ST_WR_REQ: begin
                // AW and W finish independently; leave once both have handshaken.
                if ((w_aw_done || w_aw_fire) && (w_w_done || w_w_fire)) begin
                    w_state_nxt = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                BREADY = 1'b1;
                if (BVALID) begin
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                if (w_ar_done || w_ar_fire) begin
                    w_state_nxt = ST_RD_RESP;
                end
            end
            ST_RD_RESP: begin
                RREADY = 1'b1;
                if (RVALID) begin
                    w_state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Response payload: direction latched at accept, status/data captured on the B or R handshake.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rsp_write <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= RESP_OKAY;
        end else begin
            if (w_cmd_acc) begin
                r_rsp_write <= cmd_write;
            end
            if (r_state == ST_WR_RESP && BVALID) begin
                r_rsp_resp  <= BRESP;
                r_rsp_rdata <= '0;
            end
            if (r_state == ST_RD_RESP && RVALID) begin
                r_rsp_resp  <= RRESP;
                r_rsp_rdata <= RDATA;
            end
        end
    end

    assign rsp_write = r_rsp_write;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_resp  = r_rsp_resp;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a vector table of commands driven against a small slave memory.
// Latency: checks VALID one cycle after accept and rsp_valid one cycle after the B/R handshake.
// Backpressure: slave READY delays, early RVALID, held rsp_ready and a mid-read reset.
module tb_axi_lite_master;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    always #5 ACLK = ~ACLK;

    axi_lite_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .busy      (busy),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .AWADDR    (AWADDR),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .BRESP     (BRESP),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARADDR    (ARADDR),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          a_dly;      // cycles before AWREADY / ARREADY
        int          w_dly;      // cycles before WREADY
        bit          early;      // read: RVALID raised while AR is still pending
        logic [1:0]  slv_resp;   // BRESP / RRESP returned by the slave
        int          hold;       // cycles rsp_ready is held low
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t        vecs [7];
    logic [31:0] mem [64];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One full command: accept, request channels, B or R, then response hand-back.
    task automatic run_vec(input vec_t v);
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_wstrb;
        bit          a_hs;
        bit          w_hs;
        bit          r_hs;
        int          cyc;
        s_addr  = '0;
        s_wdata = '0;
        s_wstrb = '0;

        @(negedge ACLK);
        chk("idle cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_wstrb = v.wstrb;
        @(negedge ACLK);
        // Keep a junk command pending while busy; it must be ignored.
        cmd_write = ~v.wr;
        cmd_addr  = 32'hDEAD_0000;
        cmd_wdata = 32'h5555_AAAA;
        cmd_wstrb = 4'h0;
        chk("busy cmd_ready", cmd_ready, 0);
        chk("busy flag", busy, 1);

        a_hs = 1'b0;
        w_hs = !v.wr;
        cyc  = 0;
        if (v.early) begin
            RVALID = 1'b1;
            RDATA  = mem[v.addr[7:2]];
            RRESP  = v.slv_resp;
        end
        while (!(a_hs && w_hs) && cyc < 50) begin
            if (v.wr) begin
                AWREADY = (cyc >= v.a_dly);
                WREADY  = (cyc >= v.w_dly);
                chk("awvalid", AWVALID, !a_hs);
                chk("wvalid", WVALID, !w_hs);
                if (!a_hs) chk("awaddr", AWADDR, v.addr);
                if (!w_hs) begin
                    chk("wdata", WDATA, v.wdata);
                    chk("wstrb", WSTRB, v.wstrb);
                end
                chk("bready during req", BREADY, 0);
                if (AWVALID && AWREADY) begin a_hs = 1'b1; s_addr = AWADDR; end
                if (WVALID && WREADY) begin w_hs = 1'b1; s_wdata = WDATA; s_wstrb = WSTRB; end
            end else begin
                ARREADY = (cyc >= v.a_dly);
                chk("arvalid", ARVALID, 1);
                chk("araddr", ARADDR, v.addr);
                chk("rready during req", RREADY, 0);
                if (ARVALID && ARREADY) begin a_hs = 1'b1; s_addr = ARADDR; end
            end
            cyc++;
            @(negedge ACLK);
        end
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        ARREADY = 1'b0;
        chk("req handshakes done", {a_hs, w_hs}, 2'b11);
        chk("req valids dropped", {AWVALID, WVALID, ARVALID}, 3'b000);

        r_hs = 1'b0;
        cyc  = 0;
        if (v.wr) begin
            BVALID = 1'b1;
            BRESP  = v.slv_resp;
            while (!r_hs && cyc < 50) begin
                chk("bready", BREADY, 1);
                if (BVALID && BREADY) r_hs = 1'b1;
                cyc++;
                @(negedge ACLK);
            end
            if (r_hs && v.slv_resp == 2'b00) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) mem[s_addr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
            end
            // BVALID lingers one cycle: a second B handshake must not happen.
            chk("bready after b", BREADY, 0);
            BVALID = 1'b0;
            BRESP  = 2'b00;
        end else begin
            RVALID = 1'b1;
            RDATA  = mem[s_addr[7:2]];
            RRESP  = v.slv_resp;
            while (!r_hs && cyc < 50) begin
                chk("rready", RREADY, 1);
                if (RVALID && RREADY) r_hs = 1'b1;
                cyc++;
                @(negedge ACLK);
            end
            chk("rready after r", RREADY, 0);
            RVALID = 1'b0;
            RDATA  = '0;
            RRESP  = 2'b00;
        end
        chk("b/r handshake", r_hs, 1);

        for (int h = 0; h <= v.hold; h++) begin
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_write", rsp_write, v.wr);
            chk("rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("rsp_resp", rsp_resp, v.exp_resp);
            chk("rsp cmd_ready", cmd_ready, 0);
            if (h == v.hold) begin
                rsp_ready = 1'b1;
                cmd_valid = 1'b0;
            end
            @(negedge ACLK);
        end
        rsp_ready = 1'b0;
        chk("idle after rsp", {rsp_valid, busy, cmd_ready}, 3'b001);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        //           wr    addr        wdata         strb     a  w  early slv    hold exp_rdata     exp_resp
        vecs[0] = '{1'b1, 32'h04, 32'hA1B2_C3D4, 4'hF,    0, 0, 1'b0, 2'b00, 0, 32'h0,        2'b00};
        vecs[1] = '{1'b1, 32'h08, 32'h1122_3344, 4'b0101, 3, 0, 1'b0, 2'b00, 0, 32'h0,        2'b00};
        vecs[2] = '{1'b0, 32'h04, 32'h0,         4'h0,    0, 0, 1'b0, 2'b00, 5, 32'hA1B2_C3D4, 2'b00};
        vecs[3] = '{1'b0, 32'h08, 32'h0,         4'h0,    2, 0, 1'b1, 2'b00, 0, 32'h0022_0044, 2'b00};
        vecs[4] = '{1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF,    0, 2, 1'b0, 2'b10, 1, 32'h0,        2'b10};
        vecs[5] = '{1'b0, 32'h40, 32'h0,         4'h0,    1, 0, 1'b0, 2'b11, 0, 32'h0,        2'b11};
        vecs[6] = '{1'b0, 32'h04, 32'h0,         4'h0,    0, 0, 1'b0, 2'b00, 0, 32'hA1B2_C3D4, 2'b00};

        ARESET    = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 1'b0;
        AWREADY = 1'b0; WREADY = 1'b0; ARREADY = 1'b0;
        BVALID = 1'b0; BRESP = 2'b00;
        RVALID = 1'b0; RDATA = '0; RRESP = 2'b00;
        repeat (2) @(negedge ACLK);
        chk("reset handshakes", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy, cmd_ready}, 8'b0000_0001);
        chk("reset awaddr", AWADDR, 0);
        chk("reset araddr", ARADDR, 0);
        chk("reset wdata/wstrb", {WDATA, WSTRB}, 0);
        chk("reset rsp payload", {rsp_rdata, rsp_resp}, 0);
        ARESET = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset while waiting in RD_RESP with RREADY high.
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h08;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        chk("mid-read arvalid", ARVALID, 1);
        ARREADY = 1'b1;
        @(negedge ACLK);
        ARREADY = 1'b0;
        chk("mid-read rready", RREADY, 1);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        chk("post-reset handshakes", {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, busy, cmd_ready}, 8'b0000_0001);
        chk("post-reset payload", {ARADDR, rsp_rdata, rsp_resp}, 0);

        run_vec(vecs[6]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite master that turns a simple command/response interface into AXI-Lite write and read transactions.
- Sits directly upstream of the AXI-Lite slave memory: drives its AW/W/AR channels and consumes its B/R channels.
- Used by testbench sequencers and the system controller to issue register and byte-memory accesses.

Parameters:
- ADDR_W, 32, AXI address width (AWADDR, ARADDR, cmd_addr)
- DATA_W, 32, AXI data width; STRB_W = DATA_W/8 (derived)

Ports:
- ACLK  in  1  clock; all logic on the rising edge
- ARESET  in  1  synchronous active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master accepts a command (only in IDLE)
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  transaction address
- cmd_wdata  in  DATA_W  write data
- cmd_wstrb  in  STRB_W  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_write  out  1  echo of cmd_write for this response
- rsp_rdata  out  DATA_W  read data (0 for writes)
- rsp_resp  out  2  BRESP or RRESP as captured
- busy  out  1  high whenever state != IDLE
- AWVALID/AWREADY  out/in  1  write address handshake; AWADDR  out  ADDR_W
- WVALID/WREADY  out/in  1  write data handshake; WDATA  out  DATA_W; WSTRB  out  STRB_W
- BVALID  in  1; BREADY  out  1; BRESP  in  2  write response
- ARVALID/ARREADY  out/in  1  read address handshake; ARADDR  out  ADDR_W
- RVALID  in  1; RREADY  out  1; RDATA  in  DATA_W; RRESP  in  2  read response

Behaviour:
- Reset (ARESET=1 at a rising edge): state=IDLE; all VALID/READY outputs 0; AWADDR, ARADDR, WDATA, WSTRB, rsp_rdata and rsp_resp all 0; rsp_valid 0; busy 0.
- Reset mid-transaction aborts immediately; no channel is left with VALID asserted.
- Handshake rule: a transfer occurs on a rising edge where VALID && READY. Once asserted, a VALID holds with stable payload until its handshake completes. VALID never waits on READY.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready=1. On cmd_valid, register the command; next cycle AWVALID=WVALID=1 (write → WR_REQ) or ARVALID=1 (read → RD_REQ).
- Latency: VALID is asserted the cycle after command acceptance.
- WR_REQ: AW and W are tracked by independent done flags. Each VALID drops the cycle after its own handshake. AW and W may complete in the same cycle or in either order. When both are done → WR_RESP with BREADY=1.
- WR_RESP: on BVALID&&BREADY, capture BRESP, set rsp_rdata=0, BREADY→0, go to RSP.
- RD_REQ: on ARVALID&&ARREADY, ARVALID→0, RREADY→1, go to RD_RESP.
- RD_RESP: on RVALID&&RREADY, capture RDATA/RRESP, RREADY→0, go to RSP.
- BREADY and RREADY are asserted only in their response states. A BVALID or RVALID arriving earlier is not accepted until then.
- RSP: rsp_valid=1, outputs stable. On rsp_ready → IDLE.
- A new command is accepted no earlier than the cycle after the rsp handshake; there is no cmd/rsp overlap.
- cmd_valid while not in IDLE is ignored (cmd_ready=0).
- No timeout: a hung slave keeps the master in its state until reset.
- Unused address bits are passed through unmodified; no alignment checks.

Decomposition:
- Shared package axi_lite_pkg: AXI response encodings (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11), master state encoding, default ADDR_W/DATA_W.
- One sub-module is natural: axi_lite_hs_reg, a VALID-hold/done-flag cell instantiated for AW, W and AR.

Test Plan:
- Write: cmd write addr=0x04, data=0xA1B2C3D4, strb=4'hF; slave readies AW and W in the same cycle, BRESP=00 → AWADDR=0x04 and WDATA=0xA1B2C3D4 seen; rsp_valid with rsp_resp=00, rsp_write=1.
- Skewed write: AWREADY delayed 3 cycles, WREADY immediate, strb=4'b0101 → WVALID drops first; AWVALID holds with stable AWADDR until accepted; exactly one B handshake.
- Read: addr=0x04 after the write above, slave returns RDATA=0xA1B2C3D4, RRESP=00 → rsp_rdata=0xA1B2C3D4, rsp_write=0.
- Response back-pressure: hold rsp_ready=0 for 5 cycles → rsp_valid and payload stay stable; cmd_ready=0 throughout; IDLE one cycle after rsp_ready.
- Error: slave returns BRESP=2'b10 on a write to addr=0x40 → rsp_resp=2'b10.
- Reset mid-read: ARESET asserted while in RD_RESP (RREADY=1) → next edge all VALID/READY=0, busy=0, cmd_ready=1, and a following read completes normally.
